// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution: raster-order pixels in, unpadded (IMG_W-2)x(IMG_H-2) results out.
// Window from two line buffers, 3-stage multiply / sum-minus-bias / truncate(+ReLU) pipeline.
module conv3x3_stream #(
    parameter int IMG_W   = 10,
    parameter int IMG_H   = 10,
    parameter int DATA_W  = 32,
    parameter int RELU_EN = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_pixel,
    input  logic [9*DATA_W-1:0] mask,
    input  logic [DATA_W-1:0]   bias,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_pixel,
    output logic                frame_done
);
    localparam int STAGES = 3;
    localparam int PW     = 2*DATA_W;
    localparam int SW     = 2*DATA_W + 4;
    localparam int CW     = $clog2(IMG_W);
    localparam int RW     = $clog2(IMG_H);

    logic [CW-1:0]            col;
    logic [RW-1:0]            row;
    logic [STAGES:0]          vld_pipe;
    logic [STAGES:0]          last_pipe;
    logic                     en, acc, launch, col_last, row_last;

    logic signed [DATA_W-1:0] lb1 [IMG_W];
    logic signed [DATA_W-1:0] lb2 [IMG_W];
    logic signed [DATA_W-1:0] win [9];
    logic signed [DATA_W-1:0] mask_q [9];
    logic signed [DATA_W-1:0] bias_q, bias_s1;
    logic signed [PW-1:0]     prod_q [9];
    logic signed [SW-1:0]     sum_c, sum_q;
    logic [DATA_W-1:0]        res_c;

    assign out_valid  = vld_pipe[STAGES];
    assign en         = !out_valid || out_ready;
    assign in_ready   = en && !reset;
    assign acc        = in_valid && in_ready;
    assign col_last   = (col == CW'(IMG_W-1));
    assign row_last   = (row == RW'(IMG_H-1));
    // Window centred at (row-1, col-1) is complete once this pixel lands.
    assign launch     = acc && (row >= RW'(2)) && (col >= CW'(2));
    assign frame_done = out_valid && out_ready && last_pipe[STAGES];

    always_comb begin
        sum_c = '0;
        for (int k = 0; k < 9; k++)
            sum_c = sum_c + SW'(prod_q[k]);
        sum_c = sum_c - SW'(bias_s1);
    end

    always_comb begin
        res_c = sum_q[DATA_W-1:0];
        if (RELU_EN != 0 && sum_q < 0)
            res_c = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col       <= '0;
            row       <= '0;
            vld_pipe  <= '0;
            last_pipe <= '0;
            out_pixel <= '0;
        end else begin
            if (acc) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (en) begin
                vld_pipe  <= {vld_pipe[STAGES-1:0], launch};
                last_pipe <= {last_pipe[STAGES-1:0], launch && row_last && col_last};
                if (vld_pipe[STAGES-1])
                    out_pixel <= res_c;
            end
        end
    end

    // Datapath: no reset needed, validity is tracked by vld_pipe.
    always_ff @(posedge clk) begin
        if (acc) begin
            lb1[col] <= in_pixel;
            lb2[col] <= lb1[col];
            win[0] <= win[1]; win[1] <= win[2]; win[2] <= lb2[col];
            win[3] <= win[4]; win[4] <= win[5]; win[5] <= lb1[col];
            win[6] <= win[7]; win[7] <= win[8]; win[8] <= in_pixel;
            if (col == '0 && row == '0) begin
                for (int k = 0; k < 9; k++)
                    mask_q[k] <= mask[k*DATA_W +: DATA_W];
                bias_q <= bias;
            end
        end
        if (en) begin
            for (int k = 0; k < 9; k++)
                prod_q[k] <= PW'(win[k]) * PW'(mask_q[k]);
            // Bias rides with the products so a new frame's latch cannot leak into old windows.
            bias_s1 <= bias_q;
            sum_q   <= sum_c;
        end
    end
endmodule

// File: tb/tb_conv3x3_stream.sv
// Scoreboard bench for conv3x3_stream on a 4x4 image; a plain and a ReLU instance run in lockstep.
module tb_conv3x3_stream;
    localparam int W = 4;
    localparam int H = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic [DW-1:0]   in_pixel;
    logic [9*DW-1:0] mask;
    logic [DW-1:0]   bias;
    logic            out_ready;
    logic            in_ready, out_valid, frame_done;
    logic [DW-1:0]   out_pixel;
    logic            in_ready_r, out_valid_r, frame_done_r;
    logic [DW-1:0]   out_pixel_r;

    typedef struct {
        logic [DW-1:0] v;
        logic          last;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   fd_cnt = 0;
    int   first_ov = -1;
    int   acc10 = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv3x3_stream #(.IMG_W(W), .IMG_H(H), .DATA_W(DW), .RELU_EN(0)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pixel(in_pixel), .mask(mask), .bias(bias), .out_valid(out_valid),
        .out_ready(out_ready), .out_pixel(out_pixel), .frame_done(frame_done)
    );

    conv3x3_stream #(.IMG_W(W), .IMG_H(H), .DATA_W(DW), .RELU_EN(1)) u_relu (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_r),
        .in_pixel(in_pixel), .mask(mask), .bias(bias), .out_valid(out_valid_r),
        .out_ready(out_ready), .out_pixel(out_pixel_r), .frame_done(frame_done_r)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops the scoreboard whenever an output is handed over.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid && first_ov < 0) first_ov = cyc;
        if (frame_done) fd_cnt++;
        if (out_valid && out_ready) begin
            if (q0.size() == 0) fail_now("unexpected output");
            else begin
                e = q0.pop_front();
                chk("out_pixel", out_pixel, e.v);
                chk("frame_done", {31'd0, frame_done}, {31'd0, e.last});
            end
        end
        if (out_valid_r && out_ready) begin
            if (q1.size() == 0) fail_now("unexpected relu output");
            else begin
                e = q1.pop_front();
                chk("relu out_pixel", out_pixel_r, e.v);
                chk("relu frame_done", {31'd0, frame_done_r}, {31'd0, e.last});
            end
        end
    end

    task automatic expect4(input logic [DW-1:0] a, b, c, d, ar, br, cr, dr);
        q0.push_back('{a, 1'b0}); q0.push_back('{b, 1'b0});
        q0.push_back('{c, 1'b0}); q0.push_back('{d, 1'b1});
        q1.push_back('{ar, 1'b0}); q1.push_back('{br, 1'b0});
        q1.push_back('{cr, 1'b0}); q1.push_back('{dr, 1'b1});
    endtask

    // Entered and left at posedge+1; returns after the pixel is accepted.
    task automatic send(input logic [DW-1:0] v);
        logic rdy;
        int   n;
        in_valid = 1'b1;
        in_pixel = v;
        n = 0;
        forever begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            if (++n > 100) begin
                fail_now("send timeout");
                break;
            end
        end
    endtask

    task automatic send_frame();
        for (int i = 0; i < W*H; i++) send(DW'(i));
        in_valid = 1'b0;
    endtask

    task automatic set_mask_all(input logic [DW-1:0] v);
        for (int k = 0; k < 9; k++) mask[k*DW +: DW] = v;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q0.size() != 0 || q1.size() != 0) begin
            @(negedge clk);
            if (++n > 60) begin
                fail_now("drain timeout");
                q0.delete();
                q1.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int   fd0;
        logic [DW-1:0] held;
        int   n;
        reset = 1'b1; in_valid = 1'b0; in_pixel = '0; out_ready = 1'b1;
        bias = '0;
        set_mask_all(1);
        @(negedge clk);
        chk("reset in_ready", {31'd0, in_ready}, 0);
        chk("reset out_valid", {31'd0, out_valid}, 0);
        chk("reset out_pixel", out_pixel, 0);
        chk("reset frame_done", {31'd0, frame_done}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("in_ready after reset", {31'd0, in_ready}, 1);
        @(posedge clk); #1;

        // Sum kernel, plus first-output latency.
        expect4(45, 54, 81, 90, 45, 54, 81, 90);
        for (int i = 0; i < W*H; i++) begin
            send(DW'(i));
            if (i == 10) acc10 = cyc;
        end
        in_valid = 1'b0;
        drain();
        chk("latency", DW'(first_ov - acc10), 3);

        // Bias 50: negative first result, clamped only on the ReLU instance.
        bias = 50;
        expect4(32'hFFFF_FFFB, 4, 31, 40, 0, 4, 31, 40);
        send_frame();
        drain();

        // Identity kernel.
        bias = 0;
        mask = '0;
        mask[4*DW +: DW] = 1;
        expect4(5, 6, 9, 10, 5, 6, 9, 10);
        send_frame();
        drain();

        // Backpressure: hold out_ready low while results sit in the pipe.
        set_mask_all(1);
        out_ready = 1'b0;
        expect4(45, 54, 81, 90, 45, 54, 81, 90);
        for (int i = 0; i < 11; i++) send(DW'(i));
        fork
            begin
                for (int i = 11; i < W*H; i++) send(DW'(i));
                in_valid = 1'b0;
            end
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!out_valid && n < 20);
                if (!out_valid) fail_now("stall out_valid timeout");
                held = out_pixel;
                chk("stall first value", held, 45);
                repeat (5) begin
                    @(negedge clk);
                    chk("stall out_valid", {31'd0, out_valid}, 1);
                    chk("stall in_ready", {31'd0, in_ready}, 0);
                    chk("stall out_pixel", out_pixel, held);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Mask change mid-frame takes effect only at the next frame; frames back-to-back.
        fd0 = fd_cnt;
        expect4(45, 54, 81, 90, 45, 54, 81, 90);
        expect4(90, 108, 162, 180, 90, 108, 162, 180);
        for (int i = 0; i < W*H; i++) begin
            send(DW'(i));
            if (i == 5) set_mask_all(2);
        end
        for (int i = 0; i < W*H; i++) send(DW'(i));
        in_valid = 1'b0;
        drain();
        chk("frame_done pulses", DW'(fd_cnt - fd0), 2);

        // Reset after a partial frame, then a full frame with the sum kernel.
        set_mask_all(1);
        for (int i = 0; i < 7; i++) send(DW'(i));
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("midreset out_valid", {31'd0, out_valid}, 0);
        chk("midreset in_ready", {31'd0, in_ready}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        expect4(45, 54, 81, 90, 45, 54, 81, 90);
        send_frame();
        drain();
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
